// File: rtl/ntt_pkg.sv
// ntt_pkg: shared NTT widths, modulus, coefficient type and drain FSM states.
package ntt_pkg;
    localparam int DATA_WIDTH_PER_INPUT = 28;
    localparam int MODULUS = 268369921;
    typedef logic [DATA_WIDTH_PER_INPUT-1:0] coeff_t;
    typedef enum logic {IDLE, DRAIN} drain_state_t;
endpackage

// File: rtl/ntt_coeff_reduce.sv
// ntt_coeff_reduce: single conditional subtract of the modulus.
module ntt_coeff_reduce import ntt_pkg::*; #(
    parameter int W = DATA_WIDTH_PER_INPUT,
    parameter int M = MODULUS
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);
    localparam logic [W-1:0] MV = W'(M);
    assign y = (a >= MV) ? a - MV : a;
endmodule

// File: rtl/ntt_input_gather.sv
// ntt_input_gather: reduces a coefficient stream into a ping-pong polynomial buffer
// and drains each full polynomial as a contiguous burst of parallel beats.
module ntt_input_gather #(
    parameter int DATA_WIDTH_PER_INPUT = ntt_pkg::DATA_WIDTH_PER_INPUT,
    parameter int INPUT_PER_CYCLE = 32,
    parameter int N = 1024,
    parameter int MODULUS = ntt_pkg::MODULUS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH_PER_INPUT-1:0] in_data,
    input  logic                            in_last,
    input  logic                            out_hold,
    output logic                            out_valid,
    output logic                            out_start,
    output logic                            out_last,
    output logic [DATA_WIDTH_PER_INPUT-1:0] out_data [INPUT_PER_CYCLE],
    output logic                            err_framing
);
    import ntt_pkg::*;
    localparam int W = DATA_WIDTH_PER_INPUT;
    localparam int P = INPUT_PER_CYCLE;
    localparam int BEATS = N / P;
    localparam int LW = P > 1 ? $clog2(P) : 1;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    logic [W-1:0] mem [2][BEATS][P];
    logic [W-1:0] in_red;
    logic [W-1:0] rd_red [P];
    logic [LW-1:0] wr_lane;
    logic [BW-1:0] wr_beat, beat, rd_beat;
    logic fill_bank, drain_bank;
    logic [1:0] full;
    drain_state_t state;
    logic accept, fill_end, drain_go, drain_end;
    assign in_ready = !full[fill_bank];
    assign accept = in_valid && in_ready;
    assign fill_end = accept && wr_beat == BW'(BEATS - 1) && wr_lane == LW'(P - 1);
    assign drain_go = state == IDLE && full[drain_bank] && !out_hold;
    assign drain_end = state == DRAIN && beat == BW'(BEATS - 1);
    assign rd_beat = state == IDLE ? '0 : beat + 1'b1;
    ntt_coeff_reduce #(.W(W), .M(MODULUS)) u_in_red (.a(in_data), .y(in_red));
    // Output-side normaliser keeps beats canonical even if a bank holds an unreduced word.
    for (genvar l = 0; l < P; l++) begin : g_norm
        ntt_coeff_reduce #(.W(W), .M(MODULUS)) u_norm (.a(mem[drain_bank][rd_beat][l]), .y(rd_red[l]));
    end
    always_ff @(posedge clk) begin
        if (accept) mem[fill_bank][wr_beat][wr_lane] <= in_red;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_lane <= '0;
            wr_beat <= '0;
            fill_bank <= 1'b0;
            drain_bank <= 1'b0;
            full <= '0;
            state <= IDLE;
            beat <= '0;
            err_framing <= 1'b0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_last <= 1'b0;
            for (int i = 0; i < P; i++) out_data[i] <= '0;
        end else begin
            if (accept) begin
                wr_lane <= (wr_lane == LW'(P - 1)) ? '0 : wr_lane + 1'b1;
                if (wr_lane == LW'(P - 1)) wr_beat <= fill_end ? '0 : wr_beat + 1'b1;
                if (in_last != fill_end) err_framing <= 1'b1;
                if (fill_end) fill_bank <= ~fill_bank;
            end
            // Fill and drain always own different banks, so set and clear never collide.
            full <= (full & ~(2'(drain_end) << drain_bank)) | (2'(fill_end) << fill_bank);
            if (state == IDLE) begin
                if (drain_go) begin
                    state <= DRAIN;
                    beat <= '0;
                    out_valid <= 1'b1;
                    out_start <= 1'b1;
                    out_last <= (BEATS == 1);
                end
            end else if (drain_end) begin
                state <= IDLE;
                drain_bank <= ~drain_bank;
                out_valid <= 1'b0;
                out_start <= 1'b0;
                out_last <= 1'b0;
            end else begin
                beat <= beat + 1'b1;
                out_start <= 1'b0;
                out_last <= (beat == BW'(BEATS - 2));
            end
            if (drain_go || (state == DRAIN && !drain_end))
                for (int i = 0; i < P; i++) out_data[i] <= rd_red[i];
        end
    end
endmodule

// File: tb/tb_ntt_input_gather.sv
// tb_ntt_input_gather: self-checking bench with a coefficient-queue reference model.
module tb_ntt_input_gather;
    import ntt_pkg::*;
    localparam int W = 28;
    localparam int P = 32;
    localparam int NN = 1024;
    localparam int BEATS = NN / P;
    localparam int M = MODULUS;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_hold = 1'b0;
    logic [W-1:0] in_data = '0;
    logic in_ready, out_valid, out_start, out_last, err_framing;
    logic [W-1:0] out_data [P];

    int n_cmp = 0, n_err = 0, cyc = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] stim [NN];
    logic [W-1:0] burst_buf [NN];
    logic [W-1:0] ref_buf [NN];
    int start_cyc [$];
    int last_cyc [$];
    int beat_idx = 0, beats_seen = 0, bad_lanes = 0;
    int last_acc_cyc = 0, first_acc_cyc = 0;

    ntt_input_gather dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_hold(out_hold), .out_valid(out_valid), .out_start(out_start),
        .out_last(out_last), .out_data(out_data), .err_framing(err_framing)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected beats are the accepted coefficients, reduced, consumed P at a time.
    always @(negedge clk) begin
        if (rst) begin
            beat_idx = 0;
            exp_q.delete();
        end else if (out_valid) begin
            beats_seen++;
            if (exp_q.size() < P) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                bad_lanes = 0;
                for (int l = 0; l < P; l++) begin
                    if (out_data[l] !== exp_q[l]) bad_lanes++;
                    burst_buf[beat_idx * P + l] = out_data[l];
                end
                for (int l = 0; l < P; l++) void'(exp_q.pop_front());
                chk("beat_bad_lanes", bad_lanes, 0);
            end
            chk("out_start", out_start, beat_idx == 0);
            chk("out_last", out_last, beat_idx == BEATS - 1);
            if (beat_idx == 0) start_cyc.push_back(cyc);
            if (beat_idx == BEATS - 1) begin
                last_cyc.push_back(cyc);
                beat_idx = 0;
            end else beat_idx++;
        end else if (beat_idx != 0) begin
            chk("burst_gap", 1, 0);
            beat_idx = 0;
        end
    end

    task automatic send_poly(input int duty, input int bad_idx, output int stalls);
        int k = 0, wait_c = 0;
        bit chk_err = 0;
        stalls = 0;
        while (k < NN) begin
            @(negedge clk);
            if (chk_err) begin
                chk("err_framing_set", err_framing, 1);
                chk_err = 0;
            end
            in_valid = duty >= 100 || $urandom_range(0, 99) < duty;
            in_data = stim[k];
            in_last = bad_idx == -2 ? 1'b0 : (k == NN - 1 || k == bad_idx);
            if (in_valid && in_ready) begin
                exp_q.push_back(W'(longint'(stim[k]) % M));
                if (k == 0) first_acc_cyc = cyc;
                if (k == bad_idx) begin
                    chk("err_framing_before", err_framing, 0);
                    chk_err = 1;
                end
                last_acc_cyc = cyc;
                k++;
                wait_c = 0;
            end else begin
                if (in_valid) stalls++;
                wait_c++;
                if (wait_c > 5000) begin
                    chk("send_timeout", k, NN);
                    break;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        if (chk_err || bad_idx == -2) chk("err_framing_set", err_framing, 1);
    endtask

    task automatic wait_bursts(input int n);
        int t = 0;
        while (last_cyc.size() < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("burst_count", last_cyc.size(), n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_coeff();
        return $urandom_range(0, 1) ? W'($urandom_range(0, M - 1)) : W'($urandom_range(M, (1 << W) - 1));
    endfunction

    typedef struct {
        int idx;
        logic [W-1:0] din;
        logic [W-1:0] exp;
    } red_vec_t;
    red_vec_t rv [6];

    initial begin
        int stalls, b0, bad, t;
        rv[0] = '{0, W'(M + 5), W'(5)};
        rv[1] = '{1, W'(M - 1), W'(268369920)};
        rv[2] = '{31, W'((1 << W) - 1), W'(65534)};
        rv[3] = '{32, W'(0), W'(0)};
        rv[4] = '{500, W'(M), W'(0)};
        rv[5] = '{1023, W'(12345), W'(12345)};
        repeat (2) @(negedge clk);
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_start", out_start, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_err_framing", err_framing, 0);
        chk("rst_out_data0", out_data[0], 0);
        chk("rst_out_data_last", out_data[P-1], 0);

        // Continuous stream of k = 0..N-1.
        for (int k = 0; k < NN; k++) stim[k] = W'(k);
        send_poly(100, -1, stalls);
        chk("t1_stalls", stalls, 0);
        wait_bursts(1);
        chk("t1_latency", start_cyc[0] - last_acc_cyc, 2);
        chk("t1_span", last_cyc[0] - start_cyc[0], BEATS - 1);
        chk("t1_b1_l1", burst_buf[33], 33);
        chk("t1_b31_l31", burst_buf[NN-1], NN - 1);
        chk("t1_err", err_framing, 0);
        for (int k = 0; k < NN; k++) ref_buf[k] = burst_buf[k];

        // Reduction table.
        for (int k = 0; k < NN; k++) stim[k] = W'($urandom_range(0, M - 1));
        for (int i = 0; i < 6; i++) stim[rv[i].idx] = rv[i].din;
        send_poly(100, -1, stalls);
        wait_bursts(2);
        for (int i = 0; i < 6; i++) chk($sformatf("t2_reduce_%0d", i), burst_buf[rv[i].idx], rv[i].exp);

        // Backpressure: three polynomials under out_hold.
        out_hold = 1'b1;
        b0 = beats_seen;
        for (int k = 0; k < NN; k++) stim[k] = rand_coeff();
        send_poly(100, -1, stalls);
        chk("t3_a_stalls", stalls, 0);
        for (int k = 0; k < NN; k++) stim[k] = rand_coeff();
        send_poly(100, -1, stalls);
        chk("t3_b_stalls", stalls, 0);
        chk("t3_ready_low", in_ready, 0);
        for (int k = 0; k < NN; k++) stim[k] = rand_coeff();
        fork
            send_poly(100, -1, stalls);
            begin
                repeat (20) @(negedge clk);
                chk("t3_ready_still_low", in_ready, 0);
                chk("t3_no_beats", beats_seen - b0, 0);
                out_hold = 1'b0;
            end
        join
        wait_bursts(5);
        chk("t3_gap", start_cyc[3] - last_cyc[2], 2);
        chk("t3_ready_rise", first_acc_cyc - last_cyc[2], 1);
        chk("t3_c_after_b", start_cyc[4] > last_cyc[3], 1);

        // 50% valid duty: identical to continuous case, then random data.
        for (int k = 0; k < NN; k++) stim[k] = W'(k);
        send_poly(50, -1, stalls);
        wait_bursts(6);
        bad = 0;
        for (int k = 0; k < NN; k++) if (burst_buf[k] !== ref_buf[k]) bad++;
        chk("t4_same_as_continuous", bad, 0);
        for (int k = 0; k < NN; k++) stim[k] = rand_coeff();
        send_poly(50, -1, stalls);
        wait_bursts(7);

        // Framing errors.
        for (int k = 0; k < NN; k++) stim[k] = W'(k);
        send_poly(100, 500, stalls);
        wait_bursts(8);
        chk("t5_err_sticky", err_framing, 1);
        do_reset();
        chk("t5_err_cleared", err_framing, 0);
        send_poly(100, -2, stalls);
        wait_bursts(9);
        chk("t5_missing_last_sticky", err_framing, 1);
        do_reset();
        chk("t5_err_cleared2", err_framing, 0);

        // Reset during beat 10 of a burst.
        send_poly(100, -1, stalls);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("t6_burst_began", out_start, 1);
        repeat (10) @(negedge clk);
        chk("t6_beat10_lane0", out_data[0], 320);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_valid_dropped", out_valid, 0);
        chk("t6_data_cleared", out_data[0], 0);
        chk("t6_start_low", out_start, 0);
        rst = 1'b0;
        exp_q.delete();
        b0 = beats_seen;
        repeat (40) @(negedge clk);
        chk("t6_no_more_beats", beats_seen - b0, 0);
        for (int k = 0; k < NN; k++) stim[k] = rand_coeff();
        send_poly(100, -1, stalls);
        wait_bursts(10);
        chk("t6_fresh_first", burst_buf[0], longint'(stim[0]) % M);
        chk("t6_fresh_lastc", burst_buf[NN-1], longint'(stim[NN-1]) % M);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
